// File: rtl/rx_frontend_gen2.sv
`timescale 1ns/1ps
// rx_frontend_gen2: strobed I/Q receive front end -- swap/invert, DC removal,
// IQ balance correction and output saturation, plus ADC overflow counting.
module rx_frontend_gen2 #(
    parameter int BASE       = 0,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int CORR_WIDTH = 18,
    parameter int DC_SHIFT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic                 in_stb,
    input  logic [IN_WIDTH-1:0]  adc_a,
    input  logic                 adc_ovf_a,
    input  logic [IN_WIDTH-1:0]  adc_b,
    input  logic                 adc_ovf_b,
    input  logic                 run,
    output logic [OUT_WIDTH-1:0] i_out,
    output logic [OUT_WIDTH-1:0] q_out,
    output logic                 out_stb,
    output logic [15:0]          ovf_count
);

    localparam int AW  = OUT_WIDTH + DC_SHIFT;
    localparam int AW1 = AW + 1;
    localparam int PW  = OUT_WIDTH + CORR_WIDTH;
    localparam int CW  = PW + 1;
    localparam int LSH = OUT_WIDTH - IN_WIDTH;
    localparam int PSH = CORR_WIDTH - 1;

    localparam logic [7:0] A_MODE  = 8'(BASE);
    localparam logic [7:0] A_MAG   = 8'(BASE + 1);
    localparam logic [7:0] A_PHASE = 8'(BASE + 2);
    localparam logic [7:0] A_DCI   = 8'(BASE + 3);
    localparam logic [7:0] A_DCQ   = 8'(BASE + 4);
    localparam logic [7:0] A_OVF   = 8'(BASE + 5);

    localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [CW-1:0] CMAX = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] CMIN = {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW1-1:0] AMAX1 = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW1-1:0] AMIN1 = {2'b11, {(AW-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] clip(input logic signed [CW-1:0] v);
        logic signed [OUT_WIDTH-1:0] r;
        if (v > CMAX) begin
            r = OMAX;
        end else if (v < CMIN) begin
            r = OMIN;
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat_neg(input logic signed [OUT_WIDTH-1:0] v);
        logic signed [OUT_WIDTH-1:0] r;
        if (v == OMIN) begin
            r = OMAX;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    // Returns {fixed_flag, accumulator}; a register write overrides a tracking update.
    function automatic logic [AW:0] dc_next(
        input logic                        fix,
        input logic signed [AW-1:0]        acc,
        input logic                        wr,
        input logic [31:0]                 data,
        input logic                        upd,
        input logic signed [OUT_WIDTH-1:0] y
    );
        logic signed [AW1-1:0]       sum;
        logic signed [OUT_WIDTH-1:0] dcw;
        logic [AW:0]                 r;
        sum = AW1'(acc) + AW1'(y);
        dcw = data[OUT_WIDTH-1:0];
        if (wr) begin
            if (data[31]) begin
                r = {1'b1, AW'(dcw) <<< DC_SHIFT};
            end else if (data[30]) begin
                r = {1'b0, {AW{1'b0}}};
            end else begin
                r = {1'b0, acc};
            end
        end else if (upd && !fix) begin
            if (sum > AMAX1) begin
                r = {fix, AMAX};
            end else if (sum < AMIN1) begin
                r = {fix, AMIN};
            end else begin
                r = {fix, sum[AW-1:0]};
            end
        end else begin
            r = {fix, acc};
        end
        return r;
    endfunction

    logic [5:0]                   mode_q, mode_d;
    logic signed [CORR_WIDTH-1:0] mag_q, mag_d, phase_q, phase_d;
    logic                         fix_i_q, fix_i_d, fix_q_q, fix_q_d;
    logic signed [AW-1:0]         acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [15:0]                  ovf_q, ovf_d;
    logic                         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic                         out_stb_q, out_stb_d;
    logic signed [OUT_WIDTH-1:0]  x_i_q, x_i_d, x_q_q, x_q_d;
    logic signed [OUT_WIDTH-1:0]  y_i_q, y_i_d, y_q_q, y_q_d;
    logic signed [OUT_WIDTH-1:0]  y3_i_q, y3_i_d, y3_q_q, y3_q_d;
    logic signed [PW-1:0]         p_i_q, p_i_d, p_q_q, p_q_d;
    logic signed [OUT_WIDTH-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;

    logic                         in_go_s, s1_go_s, s2_go_s, s3_go_s;
    logic signed [IN_WIDTH-1:0]   ra_s, rb_s;
    logic signed [OUT_WIDTH-1:0]  xi_s, xq_s, dc_i_s, dc_q_s, yi_s, yq_s;
    logic signed [CW-1:0]         sum_i_s, sum_q_s;
    logic [AW:0]                  dci_nxt_s, dcq_nxt_s;

    // Settings registers: mode and IQ correction coefficients.
    always_comb begin
        mode_d  = mode_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        if (set_stb) begin
            case (set_addr)
                A_MODE:  mode_d  = set_data[5:0];
                A_MAG:   mag_d   = set_data[CORR_WIDTH-1:0];
                A_PHASE: phase_d = set_data[CORR_WIDTH-1:0];
                default: mode_d  = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Overflow counter: clear beats increment, saturates at all-ones.
    always_comb begin
        ovf_d = ovf_q;
        if (set_stb && (set_addr == A_OVF)) begin
            ovf_d = 16'h0000;
        end else if (in_go_s && (adc_ovf_a || adc_ovf_b) && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'h0001;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Datapath next-state: valids flush whenever run drops.
    always_comb begin
        in_go_s  = in_stb & run;
        s1_go_s  = s1_vld_q & run;
        s2_go_s  = s2_vld_q & run;
        s3_go_s  = s3_vld_q & run;
        s1_vld_d = in_go_s;
        s2_vld_d = s1_go_s;
        s3_vld_d = s2_go_s;
        out_stb_d = s3_go_s;

        ra_s = adc_a;
        rb_s = adc_b;
        if (mode_q[0]) begin
            ra_s = adc_b;
            rb_s = adc_a;
        end else begin
            ra_s = adc_a;
        end
        if (mode_q[3]) begin
            rb_s = '0;
        end else begin
            rb_s = rb_s;
        end
        xi_s = OUT_WIDTH'(ra_s) << LSH;
        xq_s = OUT_WIDTH'(rb_s) << LSH;
        x_i_d = in_go_s ? (mode_q[1] ? sat_neg(xi_s) : xi_s) : x_i_q;
        x_q_d = in_go_s ? (mode_q[2] ? sat_neg(xq_s) : xq_s) : x_q_q;

        dc_i_s = OUT_WIDTH'(acc_i_q >>> DC_SHIFT);
        dc_q_s = OUT_WIDTH'(acc_q_q >>> DC_SHIFT);
        yi_s = mode_q[4] ? x_i_q : clip(CW'(x_i_q) - CW'(dc_i_s));
        yq_s = mode_q[4] ? x_q_q : clip(CW'(x_q_q) - CW'(dc_q_s));
        y_i_d = s1_go_s ? yi_s : y_i_q;
        y_q_d = s1_go_s ? yq_s : y_q_q;

        dci_nxt_s = dc_next(fix_i_q, acc_i_q, set_stb && (set_addr == A_DCI), set_data,
                            s1_go_s && !mode_q[4], yi_s);
        dcq_nxt_s = dc_next(fix_q_q, acc_q_q, set_stb && (set_addr == A_DCQ), set_data,
                            s1_go_s && !mode_q[4], yq_s);
        fix_i_d = dci_nxt_s[AW];
        acc_i_d = dci_nxt_s[AW-1:0];
        fix_q_d = dcq_nxt_s[AW];
        acc_q_d = dcq_nxt_s[AW-1:0];

        // Both products use the I rail; phase correction leaks I into Q.
        p_i_d  = s2_go_s ? PW'(y_i_q) * PW'(mag_q)   : p_i_q;
        p_q_d  = s2_go_s ? PW'(y_i_q) * PW'(phase_q) : p_q_q;
        y3_i_d = s2_go_s ? y_i_q : y3_i_q;
        y3_q_d = s2_go_s ? y_q_q : y3_q_q;

        sum_i_s = CW'(y3_i_q) + CW'(p_i_q >>> PSH);
        sum_q_s = CW'(y3_q_q) + CW'(p_q_q >>> PSH);
        if (s3_go_s) begin
            i_out_d = mode_q[5] ? y3_i_q : clip(sum_i_s);
            q_out_d = mode_q[5] ? y3_q_q : clip(sum_q_s);
        end else begin
            i_out_d = i_out_q;
            q_out_d = q_out_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= '0;
            mag_q     <= '0;
            phase_q   <= '0;
            fix_i_q   <= 1'b0;
            fix_q_q   <= 1'b0;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            ovf_q     <= 16'h0000;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            out_stb_q <= 1'b0;
            x_i_q     <= '0;
            x_q_q     <= '0;
            y_i_q     <= '0;
            y_q_q     <= '0;
            y3_i_q    <= '0;
            y3_q_q    <= '0;
            p_i_q     <= '0;
            p_q_q     <= '0;
            i_out_q   <= '0;
            q_out_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            mag_q     <= mag_d;
            phase_q   <= phase_d;
            fix_i_q   <= fix_i_d;
            fix_q_q   <= fix_q_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            ovf_q     <= ovf_d;
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            s3_vld_q  <= s3_vld_d;
            out_stb_q <= out_stb_d;
            x_i_q     <= x_i_d;
            x_q_q     <= x_q_d;
            y_i_q     <= y_i_d;
            y_q_q     <= y_q_d;
            y3_i_q    <= y3_i_d;
            y3_q_q    <= y3_q_d;
            p_i_q     <= p_i_d;
            p_q_q     <= p_q_d;
            i_out_q   <= i_out_d;
            q_out_q   <= q_out_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_stb   = out_stb_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_rx_frontend_gen2.sv
`timescale 1ns/1ps
// Scoreboard bench for rx_frontend_gen2: expectations are queued at drive time
// from a behavioural model and popped when out_stb fires.
module tb_rx_frontend_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'h00;
    logic [31:0] set_data = 32'h0;
    logic        in_stb = 1'b0;
    logic [15:0] adc_a = 16'h0, adc_b = 16'h0;
    logic        adc_ovf_a = 1'b0, adc_ovf_b = 1'b0;
    logic        run = 1'b0;
    logic [23:0] i_out, q_out;
    logic        out_stb;
    logic [15:0] ovf_count;

    rx_frontend_gen2 #(.BASE(0), .IN_WIDTH(16), .OUT_WIDTH(24), .CORR_WIDTH(18), .DC_SHIFT(4)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .in_stb(in_stb), .adc_a(adc_a), .adc_ovf_a(adc_ovf_a), .adc_b(adc_b), .adc_ovf_b(adc_ovf_b),
        .run(run), .i_out(i_out), .q_out(q_out), .out_stb(out_stb), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] stamp;
        logic [1:0]  kind;   // 0: latency only, 1: exact, 2: DC-settled bound on I
        logic [23:0] ei;
        logic [23:0] eq;
    } exp_t;

    exp_t        sb[$];
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    bit          sb_off = 1'b0;
    logic [5:0]  m_mode = 6'h0;
    longint      m_dci = 0, m_dcq = 0, m_mag = 0, m_phase = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic longint sat24(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic longint s18(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [23:0] ei, output logic [23:0] eq);
        longint xi, xq, yi, yq, oi, oq;
        xi = m_mode[0] ? longint'($signed(b)) : longint'($signed(a));
        xq = m_mode[0] ? longint'($signed(a)) : longint'($signed(b));
        if (m_mode[3]) xq = 0;
        xi = xi * 256;
        xq = xq * 256;
        if (m_mode[1]) xi = (xi == -64'sd8388608) ? 64'sd8388607 : -xi;
        if (m_mode[2]) xq = (xq == -64'sd8388608) ? 64'sd8388607 : -xq;
        if (m_mode[4]) begin
            yi = xi;
            yq = xq;
        end else begin
            yi = sat24(xi - m_dci);
            yq = sat24(xq - m_dcq);
        end
        if (m_mode[5]) begin
            oi = yi;
            oq = yq;
        end else begin
            oi = sat24(yi + ((yi * m_mag) >>> 17));
            oq = sat24(yq + ((yi * m_phase) >>> 17));
        end
        ei = oi[23:0];
        eq = oq[23:0];
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin : mon
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (!rst && !sb_off && out_stb) begin
            if (sb.size() == 0) begin
                check_val("spurious_out_stb", out_stb, 1'b0);
            end else begin
                e = sb.pop_front();
                check_val("latency", cyc - int'(e.stamp), 4);
                if (e.kind == 2'd1) begin
                    check_val("i_out", i_out, e.ei);
                    check_val("q_out", q_out, e.eq);
                end else if (e.kind == 2'd2) begin
                    check_val("dc_settled", ($signed(i_out) < 24'sh000020) && ($signed(i_out) > -24'sh000020), 1'b1);
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic oa, input logic ob, input int kind);
        exp_t e;
        logic [23:0] ei, eq;
        @(negedge clk);
        set_stb = 1'b0;
        in_stb = 1'b1;
        adc_a = a;
        adc_b = b;
        adc_ovf_a = oa;
        adc_ovf_b = ob;
        if (!sb_off && run) begin
            model(a, b, ei, eq);
            e.stamp = 32'(cyc);
            e.kind = 2'(kind);
            e.ei = ei;
            e.eq = eq;
            sb.push_back(e);
        end
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        in_stb = 1'b0;
        adc_ovf_a = 1'b0;
        adc_ovf_b = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        in_stb = 1'b0;
        set_stb = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb = 1'b0;
    endtask

    task automatic drain(input string tag);
        gap(6);
        check_val(tag, sb.size(), 0);
    endtask

    // Asserts reset between clock edges and checks outputs clear without an edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        in_stb = 1'b0;
        set_stb = 1'b0;
        #1;
        check_val("rst_out_stb", out_stb, 1'b0);
        check_val("rst_i_out", i_out, 24'h0);
        check_val("rst_q_out", q_out, 24'h0);
        check_val("rst_ovf", ovf_count, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        m_mode = 6'h0;
        m_dci = 0;
        m_dcq = 0;
        m_mag = 0;
        m_phase = 0;
    endtask

    initial begin
        logic [31:0] r;

        // Fixed DC offset with default coefficients
        do_reset();
        run = 1'b1;
        wr(8'h03, 32'h8000_0100);
        m_dci = 64'sd256;
        send(16'h0010, 16'h0000, 1'b0, 1'b0, 1);
        send(16'h8000, 16'h0000, 1'b0, 1'b0, 1);
        drain("drain_fixed_dc");

        // Swap and saturating inversion
        do_reset();
        run = 1'b1;
        wr(8'h00, 32'h3);  m_mode = 6'h03;
        send(16'h0100, 16'h0200, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h00, 32'h13); m_mode = 6'h13;
        send(16'h0100, 16'h8000, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h00, 32'h1C); m_mode = 6'h1C;
        send(16'h8000, 16'h5555, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h00, 32'h14); m_mode = 6'h14;
        send(16'h0001, 16'h8000, 1'b0, 1'b0, 1);
        drain("drain_swap_inv");

        // IQ correction and its saturation
        wr(8'h00, 32'h10);    m_mode = 6'h10;
        wr(8'h01, 32'h10000); m_mag = s18(18'h10000);
        wr(8'h02, 32'h08000); m_phase = s18(18'h08000);
        send(16'h1000, 16'h0000, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h02, 32'h1FFFF); m_phase = s18(18'h1FFFF);
        send(16'h7FFF, 16'h8000, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h02, 32'h0FFFF); m_phase = s18(18'h0FFFF);
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1);
        gap(6);
        wr(8'h00, 32'h30);    m_mode = 6'h30;
        send(16'h1000, 16'h2000, 1'b0, 1'b0, 1);
        drain("drain_iq");

        // Sparse strobes, random data and coefficients
        wr(8'h00, 32'h16); m_mode = 6'h16;
        r = $urandom();
        wr(8'h01, r);      m_mag = s18(r[17:0]);
        r = $urandom();
        wr(8'h02, r);      m_phase = s18(r[17:0]);
        for (int k = 0; k < 12; k++) begin
            send(16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 1);
            gap(2);
        end
        drain("drain_sparse");

        // Flush on run drop, clean restart
        for (int k = 0; k < 6; k++) send(16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 1);
        @(negedge clk);
        run = 1'b0;
        sb.delete();
        adc_a = 16'h7777;
        @(posedge clk);
        #1;
        check_val("flush_out_stb", out_stb, 1'b0);
        repeat (3) @(negedge clk);
        run = 1'b1;
        in_stb = 1'b0;
        for (int k = 0; k < 4; k++) send(16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 1);
        drain("drain_flush");

        // DC tracking convergence, then tracking clear
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 1999; k++) send(16'h0400, 16'h0000, 1'b0, 1'b0, 0);
        send(16'h0400, 16'h0000, 1'b0, 1'b0, 2);
        gap(6);
        wr(8'h03, 32'h4000_0000);
        send(16'h0400, 16'h0000, 1'b0, 1'b0, 1);
        drain("drain_dc_track");

        // Overflow counter
        do_reset();
        run = 1'b1;
        sb_off = 1'b1;
        for (int k = 0; k < 3; k++) send(16'h0001, 16'h0001, 1'b1, 1'b0, 0);
        for (int k = 0; k < 2; k++) send(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        send(16'h0001, 16'h0001, 1'b1, 1'b1, 0);
        gap(2);
        check_val("ovf_small", ovf_count, 16'd4);
        @(negedge clk);
        run = 1'b0;
        in_stb = 1'b1;
        adc_ovf_a = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        adc_ovf_a = 1'b0;
        run = 1'b1;
        check_val("ovf_drop_run0", ovf_count, 16'd4);
        @(negedge clk);
        in_stb = 1'b1;
        adc_ovf_b = 1'b1;
        set_stb = 1'b1;
        set_addr = 8'h05;
        set_data = 32'h0;
        @(negedge clk);
        set_stb = 1'b0;
        in_stb = 1'b0;
        adc_ovf_b = 1'b0;
        check_val("ovf_clr_vs_inc", ovf_count, 16'd0);
        for (int k = 0; k < 70000; k++) send(16'h0002, 16'h0003, 1'b0, 1'b1, 0);
        gap(2);
        check_val("ovf_saturate", ovf_count, 16'hFFFF);
        wr(8'h05, 32'h1);
        check_val("ovf_clear", ovf_count, 16'h0000);
        gap(6);

        // Reset in the middle of a stream
        for (int k = 0; k < 8; k++) send(16'h1234, 16'h4321, 1'b0, 1'b1, 0);
        do_reset();
        sb_off = 1'b0;
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
